// File: rtl/sound_pkg.sv
// sound_pkg: shared definitions for the tone generator.
//   state_t        - FSM state encoding (IDLE, PLAY, GAP)
//   FREQ_W         - width of the sound_freq / freq_q half-period code
//   DEF_*          - default timing values for a 25 MHz clock
//   max_int()      - helper used to size counters from parameters
package sound_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int FREQ_W           = 10;
    localparam int DEF_PRESCALE     = 25;          // 1 us per sound_freq LSB at 25 MHz
    localparam int DEF_DURATION_CYC = 12_500_000;  // 0.5 s tone
    localparam int DEF_GAP_CYC      = 2_500_000;   // hold-off after each tone

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tone_divider.sv
// tone_divider: square-wave generator for one tone.
//   clk, resetN - clock, asynchronous active-low reset
//   run         - high while the tone is playing; low clears all state
//   freq_q      - latched half period in PRESCALE units (0 = never toggle)
//   tone_out    - square wave, 0 in the first run cycle
// The half period is freq_q*PRESCALE cycles. It is realised as a prescaler
// (PRESCALE cycles per unit) feeding a unit counter (freq_q units per half
// period), so the product is never formed and cannot be truncated.
module tone_divider
    import sound_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              run,
    input  logic [FREQ_W-1:0] freq_q,
    output logic              tone_out
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRE_W-1:0]  pre_q,  pre_d;
    logic [FREQ_W-1:0] unit_q, unit_d;
    logic              tone_q, tone_d;

    always_comb begin
        pre_d  = pre_q;
        unit_d = unit_q;
        tone_d = tone_q;
        if (!run) begin
            pre_d  = '0;
            unit_d = '0;
            tone_d = 1'b0;
        end else if (freq_q != '0) begin
            if (pre_q == PRE_W'(PRESCALE - 1)) begin
                pre_d = '0;
                if (unit_q == freq_q - FREQ_W'(1)) begin
                    unit_d = '0;
                    tone_d = ~tone_q;
                end else begin
                    unit_d = unit_q + FREQ_W'(1);
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pre_q  <= '0;
            unit_q <= '0;
            tone_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            unit_q <= unit_d;
            tone_q <= tone_d;
        end
    end

    // Gating with run keeps the output low in the first GAP cycle even if
    // the last PLAY edge toggled the flop; the flop clears one cycle later.
    assign tone_out = tone_q & run;

endmodule

// File: rtl/sound_tone_gen.sv
// sound_tone_gen: plays one fixed-length square-wave tone per request.
//   clk, resetN  - clock, asynchronous active-low reset
//   enable_sound - request level; a rising edge (vs. registered copy) starts a tone
//   sound_freq   - half period in PRESCALE units, latched at request; 0 = ignore
//   tone_out     - square wave to the audio pin
//   busy         - high during PLAY and GAP
//   done         - one-cycle pulse in the first GAP cycle
// Requests are only honoured when the FSM was already IDLE in the sampling
// cycle; anything seen during PLAY/GAP is dropped, never queued.
module sound_tone_gen
    import sound_pkg::*;
#(
    parameter int PRESCALE     = DEF_PRESCALE,
    parameter int DURATION_CYC = DEF_DURATION_CYC,
    parameter int GAP_CYC      = DEF_GAP_CYC
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              enable_sound,
    input  logic [FREQ_W-1:0] sound_freq,
    output logic              tone_out,
    output logic              busy,
    output logic              done
);

    localparam int CNT_MAX = max_int(max_int(DURATION_CYC, GAP_CYC), 2);
    localparam int CNT_W   = $clog2(CNT_MAX);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [FREQ_W-1:0] freq_q,  freq_d;
    logic              en_q,    en_d;
    logic              req;

    assign req = enable_sound & ~en_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        freq_d  = freq_q;
        en_d    = enable_sound;
        case (state_q)
            IDLE: begin
                if (req && (sound_freq != '0)) begin
                    freq_d  = sound_freq;
                    state_d = PLAY;
                    cnt_d   = '0;
                end
            end
            PLAY: begin
                if (cnt_q == CNT_W'(DURATION_CYC - 1)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // en_q resets high so a request level held through reset does not fire.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            freq_q  <= '0;
            en_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            freq_q  <= freq_d;
            en_q    <= en_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == GAP) && (cnt_q == '0);

    tone_divider #(
        .PRESCALE (PRESCALE)
    ) u_tone_divider (
        .clk      (clk),
        .resetN   (resetN),
        .run      (state_q == PLAY),
        .freq_q   (freq_q),
        .tone_out (tone_out)
    );

endmodule

// File: tb/tb_sound_tone_gen.sv
module tb_sound_tone_gen;
    import sound_pkg::*;

    localparam int P   = 2;
    localparam int DUR = 40;
    localparam int GP  = 8;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              resetN = 1'b0;
    logic              enable_sound = 1'b1;
    logic [FREQ_W-1:0] sound_freq = '0;
    logic              tone_out;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    sound_tone_gen #(
        .PRESCALE     (P),
        .DURATION_CYC (DUR),
        .GAP_CYC      (GP)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .enable_sound (enable_sound),
        .sound_freq   (sound_freq),
        .tone_out     (tone_out),
        .busy         (busy),
        .done         (done)
    );

    // ---------------- counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
    endtask

    // ---------------- reference model ----------------
    // k_m: index of the current cycle within the tone (PLAY then GAP), -1 when idle.
    int   k_m = -1;
    int   hp_m = 1;
    logic prev_en_m = 1'b1;
    logic was_idle_m;
    logic [2:0] exp_q[$];   // {busy, done, tone_out}

    always @(posedge clk) begin
        if (!resetN) begin
            k_m       = -1;
            prev_en_m = 1'b1;
        end else begin
            was_idle_m = (k_m < 0);
            if (k_m >= 0) begin
                k_m++;
                if (k_m == DUR + GP) k_m = -1;
            end
            if (was_idle_m && enable_sound && !prev_en_m && sound_freq != '0) begin
                k_m  = 0;
                hp_m = int'(sound_freq) * P;
            end
            prev_en_m = enable_sound;
        end
    end

    always @(negedge clk) begin
        if (!resetN || k_m < 0)
            exp_q.push_back(3'b000);
        else
            exp_q.push_back({1'b1, (k_m == DUR), ((k_m < DUR) && ((k_m / hp_m) % 2 == 1))});
    end

    // ---------------- monitor ----------------
    logic [2:0] exp_v;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL queue_empty t=%0t actual=empty expected=entry", $time);
            end else begin
                exp_v = exp_q.pop_front();
                check("busy", busy, exp_v[2]);
                check("done", done, exp_v[1]);
                check("tone_out", tone_out, exp_v[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle request; returns one step into the first PLAY cycle.
    task automatic pulse(input logic [FREQ_W-1:0] f);
        enable_sound = 1'b1;
        sound_freq   = f;
        tick(1);
        enable_sound = 1'b0;
        sound_freq   = FREQ_W'($urandom_range(0, 1023));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset with the request level held high: must not fire on release.
        sound_freq = 10'd3;
        tick(3);
        resetN = 1'b1;
        tick(5);
        enable_sound = 1'b0;
        tick(2);

        // Single tone, freq=3.
        pulse(10'd3);
        tick(60);

        // freq=0 request is ignored.
        pulse(10'd0);
        tick(10);

        // Second request mid-tone is dropped.
        pulse(10'd3);
        tick(9);
        pulse(10'd1);
        tick(55);

        // Level held high for 100 cycles: one tone only.
        enable_sound = 1'b1;
        sound_freq   = 10'd3;
        tick(100);
        enable_sound = 1'b0;
        tick(10);

        // Half period longer than the tone: silent, but busy/done normal.
        pulse(10'd1023);
        tick(55);

        // Reset at k=20 silences the output asynchronously.
        pulse(10'd3);
        tick(20);
        resetN = 1'b0;
        #1;
        check("async_tone", tone_out, 1'b0);
        check("async_busy", busy, 1'b0);
        tick(2);
        resetN = 1'b1;
        tick(2);
        pulse(10'd3);
        tick(60);

        // Randomised requests, including overlapping and zero-frequency ones.
        repeat (20) begin
            if ($urandom_range(0, 4) == 0) pulse(10'd0);
            else if ($urandom_range(0, 5) == 0) pulse(FREQ_W'($urandom_range(20, 1023)));
            else pulse(FREQ_W'($urandom_range(1, 12)));
            tick($urandom_range(1, 70));
        end
        tick(60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
